mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) sharing one single-cycle-latency memory port.
// Data normally wins; fetch is forced through after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              _clk,
  input  logic              _reset,
  input  logic              _f_req,
  input  logic [ADDR_W-1:0] _f_addr,
  output logic              f_gnt_,
  output logic              f_rvalid_,
  output logic [DATA_W-1:0] f_rdata_,
  input  logic              _d_req,
  input  logic              _d_we,
  input  logic [ADDR_W-1:0] _d_addr,
  input  logic [DATA_W-1:0] _d_wdata,
  output logic              d_gnt_,
  output logic              d_rvalid_,
  output logic [DATA_W-1:0] d_rdata_,
  output logic [ADDR_W-1:0] mem_vptr_,
  output logic              mem_we_,
  output logic [DATA_W-1:0] mem_data_,
  input  logic [DATA_W-1:0] _mem_value,
  output logic [15:0]       f_stall_cnt_,
  input  logic              _en_trace
);

  localparam int unsigned STREAK_W   = 3;
  // A limit beyond the 3-bit streak range can never be hit, so fetch only wins when data idles.
  localparam int unsigned STREAK_SAT = (STARVE_LIMIT > 7) ? 7 : STARVE_LIMIT;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_F    = 2'd1,
    RSP_D    = 2'd2
  } rsp_e;

  rsp_e                rsp_q, rsp_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                trace_vld_q, trace_vld_d;
  logic                trace_f_q, trace_f_d;
  logic                trace_we_q, trace_we_d;
  logic [ADDR_W-1:0]   trace_addr_q, trace_addr_d;
  logic                starve_c;

  // Grant decision and memory-port mux, all in the request cycle
  always_comb begin
    starve_c = (32'(streak_q) == STARVE_LIMIT);
    f_gnt_   = 1'b0;
    d_gnt_   = 1'b0;
    if (!_reset) begin
      f_gnt_ = _f_req & (~_d_req | starve_c);
      d_gnt_ = _d_req & ~f_gnt_;
    end
    mem_vptr_ = last_addr_q;
    if (f_gnt_)      mem_vptr_ = _f_addr;
    else if (d_gnt_) mem_vptr_ = _d_addr;
    mem_we_   = d_gnt_ & _d_we;
    mem_data_ = _d_wdata;
  end

  always_comb begin
    f_rvalid_    = (rsp_q == RSP_F);
    d_rvalid_    = (rsp_q == RSP_D);
    f_rdata_     = _mem_value;
    d_rdata_     = _mem_value;
    f_stall_cnt_ = stall_q;
  end

  // Next-state for response tag, starvation streak, stall counter and trace record
  always_comb begin
    rsp_d = RSP_NONE;
    if (f_gnt_)                rsp_d = RSP_F;
    else if (d_gnt_ && !_d_we) rsp_d = RSP_D;

    streak_d = streak_q;
    if (!_f_req || f_gnt_)
      streak_d = '0;
    else if (d_gnt_ && (streak_q != STREAK_W'(STREAK_SAT)))
      streak_d = streak_q + STREAK_W'(1);

    stall_d = stall_q;
    if (_f_req && !f_gnt_ && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;

    last_addr_d = last_addr_q;
    if (f_gnt_ || d_gnt_) last_addr_d = mem_vptr_;

    trace_vld_d  = _en_trace & (f_gnt_ | d_gnt_);
    trace_f_d    = f_gnt_;
    trace_we_d   = mem_we_;
    trace_addr_d = mem_vptr_;
  end

  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      rsp_q        <= RSP_NONE;
      streak_q     <= '0;
      stall_q      <= '0;
      last_addr_q  <= '0;
      trace_vld_q  <= 1'b0;
      trace_f_q    <= 1'b0;
      trace_we_q   <= 1'b0;
      trace_addr_q <= '0;
    end else begin
      rsp_q        <= rsp_d;
      streak_q     <= streak_d;
      stall_q      <= stall_d;
      last_addr_q  <= last_addr_d;
      trace_vld_q  <= trace_vld_d;
      trace_f_q    <= trace_f_d;
      trace_we_q   <= trace_we_d;
      trace_addr_q <= trace_addr_d;
    end
  end

  // A logged grant must match the port address it drove, and fetches never write
  always_ff @(posedge _clk) begin
    if (!_reset && trace_vld_q)
      assert ((trace_addr_q == last_addr_q) && !(trace_f_q && trace_we_q));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, randomized traffic against a
// transaction-level reference model, mid-flight reset, and stall-counter saturation.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we, en_trace;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] f_rdata, d_rdata, mem_vptr, mem_data, mem_value;
  logic [15:0] stall;

  logic        s_rst, s_freq, s_dreq, s_dwe, s_en;
  logic [31:0] s_faddr, s_daddr, s_wdata, s_mem_value;
  logic        s_fgnt, s_frv, s_dgnt, s_drv, s_we;
  logic [31:0] s_frd, s_drd, s_vptr, s_data;
  logic [15:0] s_stall;
  logic        sat_done = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    ._clk(clk), ._reset(rst),
    ._f_req(f_req), ._f_addr(f_addr),
    .f_gnt_(f_gnt), .f_rvalid_(f_rvalid), .f_rdata_(f_rdata),
    ._d_req(d_req), ._d_we(d_we), ._d_addr(d_addr), ._d_wdata(d_wdata),
    .d_gnt_(d_gnt), .d_rvalid_(d_rvalid), .d_rdata_(d_rdata),
    .mem_vptr_(mem_vptr), .mem_we_(mem_we), .mem_data_(mem_data),
    ._mem_value(mem_value), .f_stall_cnt_(stall), ._en_trace(en_trace)
  );

  // Second instance whose fetch limit lies outside the streak range: fetch never wins
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) u_sat (
    ._clk(clk), ._reset(s_rst),
    ._f_req(s_freq), ._f_addr(s_faddr),
    .f_gnt_(s_fgnt), .f_rvalid_(s_frv), .f_rdata_(s_frd),
    ._d_req(s_dreq), ._d_we(s_dwe), ._d_addr(s_daddr), ._d_wdata(s_wdata),
    .d_gnt_(s_dgnt), .d_rvalid_(s_drv), .d_rdata_(s_drd),
    .mem_vptr_(s_vptr), .mem_we_(s_we), .mem_data_(s_data),
    ._mem_value(s_mem_value), .f_stall_cnt_(s_stall), ._en_trace(s_en)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  // Memory behind the port: one-cycle read latency, writes land at the grant edge
  logic [31:0] env_mem [256];
  bit          env_wr  [256];
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_vptr[7:0]] <= mem_data;
      env_wr[mem_vptr[7:0]]  <= 1'b1;
    end
    mem_value <= env_wr[mem_vptr[7:0]] ? env_mem[mem_vptr[7:0]] : pat(mem_vptr[7:0]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: transaction-level view of the arbiter and memory
  int          m_streak, m_stall, pend_kind;
  logic [31:0] m_last, pend_data;
  logic [31:0] mmem [256];

  task automatic model_reset();
    m_streak = 0; m_stall = 0; m_last = '0; pend_kind = 0; pend_data = '0;
  endtask

  task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic tr,
                      output logic og_f, output logic og_d);
    logic ef, ed, ewe;
    logic [31:0] ev;
    @(negedge clk);
    f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; en_trace = tr;
    #1;
    ef  = fr && (!dr || m_streak >= LIMIT);
    ed  = dr && !ef;
    ewe = ed && dwe;
    ev  = ef ? fa : (ed ? da : m_last);
    chk("f_gnt", 64'(f_gnt), 64'(ef));
    chk("d_gnt", 64'(d_gnt), 64'(ed));
    chk("mem_vptr", 64'(mem_vptr), 64'(ev));
    chk("mem_we", 64'(mem_we), 64'(ewe));
    if (ewe) chk("mem_data", 64'(mem_data), 64'(dwd));
    chk("f_rvalid", 64'(f_rvalid), 64'(pend_kind == 1));
    chk("d_rvalid", 64'(d_rvalid), 64'(pend_kind == 2));
    if (pend_kind == 1) chk("f_rdata", 64'(f_rdata), 64'(pend_data));
    if (pend_kind == 2) chk("d_rdata", 64'(d_rdata), 64'(pend_data));
    chk("f_stall_cnt", 64'(stall), 64'(m_stall));
    og_f = f_gnt;
    og_d = d_gnt;
    pend_kind = 0;
    if (ef) begin
      pend_kind = 1; pend_data = mmem[fa[7:0]];
    end else if (ed && !dwe) begin
      pend_kind = 2; pend_data = mmem[da[7:0]];
    end
    if (ewe) mmem[da[7:0]] = dwd;
    if (!fr || ef)  m_streak = 0;
    else if (ed)    m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
    if (fr && !ef)  m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
    if (ef || ed)   m_last = ev;
  endtask

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [1:0]  eg;    // {fetch, data} grant expected this cycle
    logic        efv;
    logic        edv;
    int          estall; // -1: not checked
  } vec_t;

  vec_t tbl[17];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_f_gnt"}, 64'(f_gnt), 64'(0));
    chk({tag, "_d_gnt"}, 64'(d_gnt), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_vptr"}, 64'(mem_vptr), 64'(0));
    chk({tag, "_f_rvalid"}, 64'(f_rvalid), 64'(0));
    chk({tag, "_d_rvalid"}, 64'(d_rvalid), 64'(0));
    chk({tag, "_stall"}, 64'(stall), 64'(0));
  endtask

  initial begin
    logic gf, gd;
    for (int i = 0; i < 256; i++) mmem[i] = pat(8'(i));
    model_reset();

    tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        2'b10, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 1'b1, 1'b0, -1};
    tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0, -1};
    tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        2'b01, 1'b0, 1'b0, -1};
    tbl[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 1'b0, 1'b1, -1};
    tbl[5]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b0, 1'b1, -1};
    tbl[7]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b0, 1'b1, -1};
    tbl[8]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b0, 1'b1, -1};
    tbl[9]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0,        2'b10, 1'b0, 1'b1, -1};
    tbl[10] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0,        2'b01, 1'b1, 1'b0, -1};
    tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 1'b0, 1'b1, 5};
    tbl[12] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        2'b10, 1'b0, 1'b0, -1};
    tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h8,  32'h0,        2'b01, 1'b1, 1'b0, -1};
    tbl[14] = '{1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,        2'b10, 1'b0, 1'b1, -1};
    tbl[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 1'b1, 1'b0, -1};
    tbl[16] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 1'b0, 1'b0, -1};

    // Reset with both requesters active: everything must stay quiet
    rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b1; en_trace = 1'b0;
    f_addr = 32'h55; d_addr = 32'h66; d_wdata = 32'h1234;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd, 1'b1, gf, gd);
      chk($sformatf("tbl%0d_gnt", i), 64'({gf, gd}), 64'(tbl[i].eg));
      chk($sformatf("tbl%0d_frv", i), 64'(f_rvalid), 64'(tbl[i].efv));
      chk($sformatf("tbl%0d_drv", i), 64'(d_rvalid), 64'(tbl[i].edv));
      if (tbl[i].efv) chk($sformatf("tbl%0d_frd", i), 64'(f_rdata), 64'(mmem[tbl[i-1].fa[7:0]]));
      if (tbl[i].edv) chk($sformatf("tbl%0d_drd", i), 64'(d_rdata), 64'(mmem[tbl[i-1].da[7:0]]));
      if (tbl[i].estall >= 0) chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].estall));
    end

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 9) < 7, 32'($urandom_range(0, 255)), $urandom_range(0, 9) < 7,
           1'($urandom), 32'($urandom_range(0, 255)), $urandom, 1'($urandom), gf, gd);

    // Reset lands between a fetch grant and its response edge
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h10; d_req = 1'b0; d_we = 1'b0;
    #1 chk("mrst_pre_fgnt", 64'(f_gnt), 64'(1));
    #1 rst = 1'b1;
    #1 check_reset_outputs("mrst_async");
    @(negedge clk);
    #1 check_reset_outputs("mrst_held");
    rst = 1'b0; f_req = 1'b0;
    #1;
    chk("mrst_rel_f_rvalid", 64'(f_rvalid), 64'(0));
    chk("mrst_rel_d_rvalid", 64'(d_rvalid), 64'(0));
    model_reset();

    for (int n = 0; n < 100; n++)
      step($urandom_range(0, 9) < 6, 32'($urandom_range(0, 255)), $urandom_range(0, 9) < 6,
           1'($urandom), 32'($urandom_range(0, 255)), $urandom, 1'($urandom), gf, gd);

    wait (sat_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Permanent contention on the second instance drives the stall counter into saturation
  initial begin
    int fseen;
    fseen = 0;
    s_rst = 1'b1; s_freq = 1'b1; s_dreq = 1'b1; s_dwe = 1'b0; s_en = 1'b0;
    s_faddr = 32'h100; s_daddr = 32'h200; s_wdata = '0; s_mem_value = '0;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
    for (int c = 1; c <= 70000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_fgnt) fseen++;
      if (c == 1000 || c == 65534 || c == 65535 || c == 70000)
        chk($sformatf("sat_stall_c%0d", c), 64'(s_stall), 64'((c > 65535) ? 65535 : c));
    end
    chk("sat_fgnt_seen", 64'(fseen), 64'(0));
    chk("sat_dgnt", 64'(s_dgnt), 64'(1));
    sat_done = 1'b1;
  end

endmodule
